// File: rtl/tdp_ram_pkg.sv
// Shared types and helpers for the true dual-port RAM and its read pipeline.
package tdp_ram_pkg;

    typedef enum logic {WRITE_FIRST, READ_FIRST} rdw_mode_e;
    typedef enum logic {CLEAR, RUN} state_e;

    // Widest word the merge helper handles; narrower words are zero-extended into it.
    localparam int MAX_DATA_WIDTH = 1024;
    localparam int MAX_BYTES      = MAX_DATA_WIDTH / 8;

    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BYTES-1:0]      byte_en
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/tdp_ram_rdpipe.sv
// Optional second read-data stage; with BYPASS set it is a plain pass-through.
module tdp_ram_rdpipe #(
    parameter int DATA_WIDTH = 32,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rdata_in,
    input  logic                  rvalid_in,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic                  rvalid_out
);

    generate
        if (BYPASS) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign rdata_out      = rdata_in;
            assign rvalid_out     = rvalid_in;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
            logic                  rvalid_q, rvalid_d;

            // Data only advances on a valid beat so the output holds between reads.
            always_comb begin
                rdata_d  = rdata_q;
                rvalid_d = rvalid_in;
                if (rvalid_in) begin
                    rdata_d = rdata_in;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign rdata_out  = rdata_q;
            assign rvalid_out = rvalid_q;
        end
    endgenerate

endmodule

// File: rtl/tdp_ram.sv
// True dual-port RAM with byte enables, post-reset clear sequencer and
// port-A-wins arbitration for same-address writes.
module tdp_ram import tdp_ram_pkg::*; #(
    parameter int        ADDR_WIDTH = 4,
    parameter int        DATA_WIDTH = 32,
    parameter int        RD_LATENCY = 1,
    parameter rdw_mode_e RDW_MODE   = WRITE_FIRST
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    busy,
    input  logic                    en_a,
    input  logic [DATA_WIDTH/8-1:0] we_a,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic [DATA_WIDTH-1:0]   wdata_a,
    output logic [DATA_WIDTH-1:0]   rdata_a,
    output logic                    rvalid_a,
    input  logic                    en_b,
    input  logic [DATA_WIDTH/8-1:0] we_b,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    input  logic [DATA_WIDTH-1:0]   wdata_b,
    output logic [DATA_WIDTH-1:0]   rdata_b,
    output logic                    rvalid_b,
    output logic                    collision
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("tdp_ram: RD_LATENCY must be 1 or 2");
        end
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
            $error("tdp_ram: DATA_WIDTH must be a multiple of 8 and fit byte_merge");
        end
    endgenerate

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_BYTES-1:0]  byte_en
    );
        return DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(old_word),
                                      MAX_DATA_WIDTH'(new_word),
                                      MAX_BYTES'(byte_en)));
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0] rdata1_a_q, rdata1_a_d, rdata1_b_q, rdata1_b_d;
    logic                  rvalid1_a_q, rvalid1_a_d, rvalid1_b_q, rvalid1_b_d;
    logic                  collision_q, collision_d;

    logic                  acc_a, acc_b, wr_a, wr_b, same_addr;
    logic [DATA_WIDTH-1:0] old_a, old_b, merged_a, merged_b;
    logic                  mem_we_a, mem_we_b;
    logic [ADDR_WIDTH-1:0] mem_addr_a;
    logic [DATA_WIDTH-1:0] mem_wdata_a, mem_wdata_b;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            if (clr_cnt_q == LAST_ADDR) begin
                state_d = RUN;
            end
        end
    end

    // On a shared write address port B's merge is folded into port A's write so A wins per byte.
    always_comb begin
        acc_a     = en_a && (state_q == RUN) && !rst;
        acc_b     = en_b && (state_q == RUN) && !rst;
        wr_a      = acc_a && (|we_a);
        wr_b      = acc_b && (|we_b);
        old_a     = mem_q[addr_a];
        old_b     = mem_q[addr_b];
        merged_a  = merge(old_a, wdata_a, we_a);
        merged_b  = merge(old_b, wdata_b, we_b);
        same_addr = wr_a && wr_b && (addr_a == addr_b);

        mem_we_a    = wr_a;
        mem_addr_a  = addr_a;
        mem_wdata_a = merged_a;
        mem_we_b    = wr_b && !same_addr;
        mem_wdata_b = merged_b;
        if (same_addr) begin
            mem_wdata_a = merge(merged_b, wdata_a, we_a);
        end
        if (state_q == CLEAR) begin
            mem_we_a    = 1'b1;
            mem_addr_a  = clr_cnt_q;
            mem_wdata_a = '0;
        end

        rvalid1_a_d = acc_a;
        rvalid1_b_d = acc_b;
        rdata1_a_d  = rdata1_a_q;
        rdata1_b_d  = rdata1_b_q;
        if (acc_a) begin
            rdata1_a_d = (RDW_MODE == WRITE_FIRST && wr_a) ? merged_a : old_a;
        end
        if (acc_b) begin
            rdata1_b_d = (RDW_MODE == WRITE_FIRST && wr_b) ? merged_b : old_b;
        end
        collision_d = same_addr && (|(we_a & we_b));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            rdata1_a_q  <= '0;
            rdata1_b_q  <= '0;
            rvalid1_a_q <= 1'b0;
            rvalid1_b_q <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rdata1_a_q  <= rdata1_a_d;
            rdata1_b_q  <= rdata1_b_d;
            rvalid1_a_q <= rvalid1_a_d;
            rvalid1_b_q <= rvalid1_b_d;
            collision_q <= collision_d;
        end
    end

    // The array has no reset; the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we_a) begin
            mem_q[mem_addr_a] <= mem_wdata_a;
        end
        if (mem_we_b) begin
            mem_q[addr_b] <= mem_wdata_b;
        end
    end

    tdp_ram_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYPASS     (RD_LATENCY == 1)
    ) u_rdpipe_a (
        .clk        (clk),
        .rst        (rst),
        .rdata_in   (rdata1_a_q),
        .rvalid_in  (rvalid1_a_q),
        .rdata_out  (rdata_a),
        .rvalid_out (rvalid_a)
    );

    tdp_ram_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYPASS     (RD_LATENCY == 1)
    ) u_rdpipe_b (
        .clk        (clk),
        .rst        (rst),
        .rdata_in   (rdata1_b_q),
        .rvalid_in  (rvalid1_b_q),
        .rdata_out  (rdata_b),
        .rvalid_out (rvalid_b)
    );

    assign busy      = (state_q == CLEAR);
    assign collision = collision_q;

endmodule

// File: tb/tb_tdp_ram.sv
// Scoreboard bench for tdp_ram: one WRITE_FIRST/latency-1 and one READ_FIRST/latency-2
// instance share stimulus and are checked against a word-array reference model.
`timescale 1ns/1ps
module tb_tdp_ram;
    import tdp_ram_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_a, en_b;
    logic [NB-1:0] we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;

    logic          busy0, busy1, collision0, collision1;
    logic          rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;
    logic [DW-1:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;

    exp_t          sb_q [2][2][$];
    int            col_q [$];
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] last_data [2][2];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;

    bit            mon_exp, mon_col;
    logic          mon_v;
    exp_t          mon_e;

    tdp_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .RDW_MODE(WRITE_FIRST)) dut_wf (
        .clk(clk), .rst(rst), .busy(busy0),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .rdata_b(rdata_b0), .rvalid_b(rvalid_b0),
        .collision(collision0)
    );

    tdp_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .RDW_MODE(READ_FIRST)) dut_rf (
        .clk(clk), .rst(rst), .busy(busy1),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .rdata_b(rdata_b1), .rvalid_b(rvalid_b1),
        .collision(collision1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic [DW-1:0] byte_mask(input logic [NB-1:0] we);
        logic [DW-1:0] m;
        for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{we[i]}};
        return m;
    endfunction

    function automatic logic get_rvalid(input int d, input int p);
        case ({d[0], p[0]})
            2'b00:   return rvalid_a0;
            2'b01:   return rvalid_b0;
            2'b10:   return rvalid_a1;
            default: return rvalid_b1;
        endcase
    endfunction

    function automatic logic [DW-1:0] get_rdata(input int d, input int p);
        case ({d[0], p[0]})
            2'b00:   return rdata_a0;
            2'b01:   return rdata_b0;
            2'b10:   return rdata_a1;
            default: return rdata_b1;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives one cycle of accesses; expected reads and collisions are queued, then the model is updated.
    task automatic applyStimulus(
        input logic ea, input logic [NB-1:0] wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
        input logic eb, input logic [NB-1:0] wb, input logic [AW-1:0] ab, input logic [DW-1:0] db
    );
        logic [DW-1:0] old_a, old_b, ma, mb;
        exp_t          e;
        en_a = ea; we_a = wa; addr_a = aa; wdata_a = da;
        en_b = eb; we_b = wb; addr_b = ab; wdata_b = db;
        old_a = model_mem[aa];
        old_b = model_mem[ab];
        ma = ea ? byte_mask(wa) : '0;
        mb = eb ? byte_mask(wb) : '0;
        for (int d = 0; d < 2; d++) begin
            if (ea) begin
                e.due  = cyc + lat(d);
                e.data = (d == 0) ? ((old_a & ~ma) | (da & ma)) : old_a;
                sb_q[d][0].push_back(e);
            end
            if (eb) begin
                e.due  = cyc + lat(d);
                e.data = (d == 0) ? ((old_b & ~mb) | (db & mb)) : old_b;
                sb_q[d][1].push_back(e);
            end
        end
        if (ea && eb && aa == ab && (wa & wb) != '0) col_q.push_back(cyc + 1);
        model_mem[ab] = (model_mem[ab] & ~mb) | (db & mb);
        model_mem[aa] = (model_mem[aa] & ~ma) | (da & ma);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic applyReset(input int hold);
        rst = 1'b1;
        en_a = 1'b0; we_a = '0; addr_a = '0; wdata_a = '0;
        en_b = 1'b0; we_b = '0; addr_b = '0; wdata_b = '0;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                while (sb_q[d][p].size() != 0 && sb_q[d][p][$].due > cyc) void'(sb_q[d][p].pop_back());
            end
        end
        while (col_q.size() != 0 && col_q[$] > cyc) void'(col_q.pop_back());
        repeat (hold) @(posedge clk);
        #1;
        checkOutput("reset busy wf", DW'(busy0), DW'(1));
        checkOutput("reset busy rf", DW'(busy1), DW'(1));
        checkOutput("reset collision wf", DW'(collision0), '0);
        checkOutput("reset collision rf", DW'(collision1), '0);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                checkOutput($sformatf("reset rvalid dut%0d port%0d", d, p), DW'(get_rvalid(d, p)), '0);
                checkOutput($sformatf("reset rdata dut%0d port%0d", d, p), get_rdata(d, p), '0);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    task automatic clearWait();
        int n = 0;
        @(negedge clk);
        while (busy0 === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checkOutput("busy cycles after reset", DW'(n), DW'(16));
        checkOutput("busy rf after clear", DW'(busy1), '0);
        @(posedge clk);
        #1;
    endtask

    task automatic sweepRead();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, '0, AW'(i), '0, 1'b1, '0, AW'(DEPTH - 1 - i), '0);
    endtask

    // Checks every scheduled read beat, forbids unscheduled ones, and checks rdata holds between beats.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    mon_exp = (sb_q[d][p].size() != 0) && (sb_q[d][p][0].due == cyc);
                    mon_v   = get_rvalid(d, p);
                    if (mon_v !== 1'b0 || mon_exp)
                        checkOutput($sformatf("rvalid dut%0d port%0d", d, p), DW'(mon_v), DW'(mon_exp));
                    if (mon_exp) begin
                        mon_e = sb_q[d][p].pop_front();
                        if (mon_v === 1'b1) begin
                            checkOutput($sformatf("rdata dut%0d port%0d", d, p), get_rdata(d, p), mon_e.data);
                            last_data[d][p] = mon_e.data;
                        end
                    end else if (rst === 1'b0) begin
                        checkOutput($sformatf("rdata hold dut%0d port%0d", d, p), get_rdata(d, p), last_data[d][p]);
                    end
                    if (rst === 1'b1) last_data[d][p] = '0;
                end
            end
            mon_col = (col_q.size() != 0) && (col_q[0] == cyc);
            if (mon_col) void'(col_q.pop_front());
            checkOutput("collision wf", DW'(collision0), DW'(mon_col));
            checkOutput("collision rf", DW'(collision1), DW'(mon_col));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int pend;
        logic [AW-1:0] ra;
        for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) last_data[d][p] = '0;
        rst = 1'b1;
        applyReset(2);
        mon_en = 1'b1;
        clearWait();
        sweepRead();

        applyStimulus(1'b1, 4'b1111, 4'd3, 32'hDEADBEEF, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, '0, 4'd3, '0);

        applyStimulus(1'b1, 4'b1111, 4'd5, 32'hAAAAAAAA, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 4'b1111, 4'd5, 32'h55555555, 1'b1, '0, 4'd5, '0);
        applyStimulus(1'b1, '0, 4'd5, '0, 1'b0, '0, '0, '0);

        applyStimulus(1'b1, 4'b0001, 4'd7, 32'h000000FF, 1'b1, 4'b1111, 4'd7, 32'hFFFFFF00);
        applyStimulus(1'b1, '0, 4'd7, '0, 1'b1, '0, 4'd7, '0);
        idle(3);

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, '0, AW'(i), '0, 1'b1, '0, AW'(i), '0);
        idle(3);

        repeat (400) begin
            ra = AW'($urandom_range(0, DEPTH - 1));
            applyStimulus($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0, ra, $urandom,
                          $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0,
                          ($urandom_range(0, 2) == 0) ? ra : AW'($urandom_range(0, DEPTH - 1)), $urandom);
        end
        idle(3);

        for (int i = 0; i < 6; i++) applyStimulus(1'b1, '0, AW'(i), '0, 1'b1, '0, AW'(i + 8), '0);
        applyReset(1);
        clearWait();
        sweepRead();

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 4'b1111, AW'(i), $urandom | 32'h1, 1'b0, '0, '0, '0);
        idle(3);
        applyReset(2);
        repeat (9) @(posedge clk);
        #1;
        applyReset(1);
        clearWait();
        sweepRead();
        idle(4);

        pend = col_q.size();
        for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) pend += sb_q[d][p].size();
        checkOutput("scoreboard drained", DW'(pend), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
